// File: rtl/status_flag_reg.sv
// status_flag_reg: processor status (P) register stage behind the 8-bit ALU.
// Holds the six architectural flags {N,V,D,I,Z,C} plus a delayed copy of I
// (i_eff) used for interrupt polling, and presents the push-formatted P byte
// and the branch-taken decision.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   alu_*              ALU carry/overflow/zero/sign results
//   upd_nvzc[3:0]      per-flag ALU update enables {N,V,Z,C}
//   flag_op[2:0]       0 none,1 CLC,2 SEC,3 CLI,4 SEI,5 CLV,6 CLD,7 SED
//   p_load, p_din      PLP/RTI full load from the data bus byte
//   bit_load           BIT: N<=p_din[7], V<=p_din[6]
//   irq_entry          interrupt/BRK entry, sets I
//   inst_done          instruction boundary pulse, samples I into i_eff
//   brk_push           value shown in bit 4 of p_out
//   br_cond[2:0]       branch opcode bits [7:5]
//   p_out              {N,V,1,brk_push,D,I,Z,C}
//   flags_nvdizc       raw stored flags
//   br_taken           branch condition result
//   irq_mask_eff       I value seen by interrupt polling
module status_flag_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic [3:0] upd_nvzc,
  input  logic [2:0] flag_op,
  input  logic       p_load,
  input  logic       bit_load,
  input  logic [7:0] p_din,
  input  logic       irq_entry,
  input  logic       inst_done,
  input  logic       brk_push,
  input  logic [2:0] br_cond,
  output logic [7:0] p_out,
  output logic [5:0] flags_nvdizc,
  output logic       br_taken,
  output logic       irq_mask_eff
);

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLV  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_SED  = 3'd7
  } flag_op_e;

  flag_op_e w_op;
  assign w_op = flag_op_e'(flag_op);

  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic r_i_eff;
  logic w_n, w_v, w_d, w_i, w_z, w_c;

  // Each flag resolves its own priority chain; conflicting controls are legal.
  always_comb begin
    w_c = r_c;
    if (p_load)                 w_c = p_din[0];
    else if (upd_nvzc[0])       w_c = alu_carry;
    else if (w_op == FOP_CLC)   w_c = 1'b0;
    else if (w_op == FOP_SEC)   w_c = 1'b1;

    w_z = r_z;
    if (p_load)                 w_z = p_din[1];
    else if (upd_nvzc[1])       w_z = alu_zero;

    w_i = r_i;
    if (irq_entry)              w_i = 1'b1;
    else if (p_load)            w_i = p_din[2];
    else if (w_op == FOP_CLI)   w_i = 1'b0;
    else if (w_op == FOP_SEI)   w_i = 1'b1;

    // Interrupt entry leaves D alone (2A03 behaviour).
    w_d = r_d;
    if (p_load)                 w_d = p_din[3];
    else if (w_op == FOP_CLD)   w_d = 1'b0;
    else if (w_op == FOP_SED)   w_d = 1'b1;

    w_v = r_v;
    if (p_load)                 w_v = p_din[6];
    else if (bit_load)          w_v = p_din[6];
    else if (upd_nvzc[2])       w_v = alu_overflow;
    else if (w_op == FOP_CLV)   w_v = 1'b0;

    w_n = r_n;
    if (p_load)                 w_n = p_din[7];
    else if (bit_load)          w_n = p_din[7];
    else if (upd_nvzc[3])       w_n = alu_sign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n     <= RESET_P[7];
      r_v     <= RESET_P[6];
      r_d     <= RESET_P[3];
      r_i     <= RESET_P[2];
      r_z     <= RESET_P[1];
      r_c     <= RESET_P[0];
      r_i_eff <= 1'b1;
    end else begin
      r_n <= w_n;
      r_v <= w_v;
      r_d <= w_d;
      r_i <= w_i;
      r_z <= w_z;
      r_c <= w_c;
      // Samples the pre-update I, giving the one-instruction CLI/SEI/PLP delay.
      if (inst_done) r_i_eff <= r_i;
    end
  end

  logic w_sel;

  always_comb begin
    unique case (br_cond[2:1])
      2'b00:   w_sel = r_n;
      2'b01:   w_sel = r_v;
      2'b10:   w_sel = r_c;
      default: w_sel = r_z;
    endcase
  end

  assign br_taken     = (w_sel == br_cond[0]);
  assign p_out        = {r_n, r_v, 1'b1, brk_push, r_d, r_i, r_z, r_c};
  assign flags_nvdizc = {r_n, r_v, r_d, r_i, r_z, r_c};
  assign irq_mask_eff = r_i_eff;

endmodule

// File: doc/status_flag_reg.md
Name: status_flag_reg

Overview:
- Processor status (P) register stage sitting directly downstream of the 8-bit ALU.
- Latches the ALU's carry/overflow/zero/sign results under per-flag update control.
- Executes the flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), PLP/RTI byte loads, BIT N/V loads and interrupt-entry I setting.
- Presents the push-formatted P byte, the branch-taken decision and the delayed interrupt-mask value used by interrupt polling.

Parameters:
- RESET_P, 8'h24, value of p_out after reset with brk_push=0. Bit 2 (I) must be 1; bits 5 and 4 are ignored.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_carry  input  1  ALU carry_out
- alu_overflow  input  1  ALU overflow
- alu_zero  input  1  ALU zero
- alu_sign  input  1  ALU sign
- upd_nvzc  input  4  per-flag ALU update enables {N,V,Z,C}
- flag_op  input  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
- p_load  input  1  load P from p_din (PLP/RTI)
- bit_load  input  1  BIT: N<=p_din[7], V<=p_din[6]
- p_din  input  8  byte from data bus
- irq_entry  input  1  interrupt/BRK entry, sets I
- inst_done  input  1  one-cycle pulse at each instruction boundary
- brk_push  input  1  value of bit 4 in p_out (1 for PHP/BRK, 0 for IRQ/NMI)
- br_cond  input  3  branch condition, 6502 opcode bits [7:5]
- p_out  output  8  {N,V,1,brk_push,D,I,Z,C}
- flags_nvdizc  output  6  raw stored flags {N,V,D,I,Z,C}
- br_taken  output  1  branch condition result
- irq_mask_eff  output  1  I value used for interrupt polling

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low; the clock port is clk and the reset port is rst_n.
- State: six flag flops {N,V,D,I,Z,C} and one i_eff flop. Bits 5 and 4 are not stored.
- Reset values: flags = RESET_P bits {7,6,3,2,1,0}; with the default this is N=V=D=Z=C=0, I=1. i_eff=1.
- Outputs at reset: p_out=8'h24 when brk_push=0, 8'h34 when brk_push=1. flags_nvdizc=6'b000100. irq_mask_eff=1.
- Reset asserted mid-instruction forces reset values immediately, regardless of clk.
- Per-flag next-state priority, highest first, evaluated independently per flag:
  - C: p_load (p_din[0]) > upd_nvzc[0] (alu_carry) > flag_op CLC/SEC > hold.
  - Z: p_load (p_din[1]) > upd_nvzc[1] (alu_zero) > hold.
  - I: irq_entry (1) > p_load (p_din[2]) > CLI/SEI > hold.
  - D: p_load (p_din[3]) > CLD/SED > hold. irq_entry does not clear D (2A03 behaviour). D has no effect on the ALU.
  - V: p_load (p_din[6]) > bit_load (p_din[6]) > upd_nvzc[2] (alu_overflow) > CLV > hold.
  - N: p_load (p_din[7]) > bit_load (p_din[7]) > upd_nvzc[3] (alu_sign) > hold.
- Simultaneous controls that conflict are legal and resolved only by the priorities above. Example: upd_nvzc[0]=1 with SEC in the same cycle gives C=alu_carry.
- BIT instruction: the sequencer asserts bit_load together with upd_nvzc=4'b0010 (Z from an AND result).
- Latency: every flag update is visible on p_out, flags_nvdizc and br_taken in the cycle after the enabling edge.
- p_out and br_taken are combinational from the flag flops and brk_push/br_cond. There is no combinational path from ALU inputs to outputs.
- br_taken: the selected flag is br_cond[2:1]: 00 N, 01 V, 10 C, 11 Z. br_taken = selected flag == br_cond[0].
  - 000 BPL, 001 BMI, 010 BVC, 011 BVS, 100 BCC, 101 BCS, 110 BNE, 111 BEQ.
- i_eff: on a clk edge with inst_done=1, i_eff <= current I flop value (pre-update). Otherwise it holds.
  - An I write in the same cycle as inst_done is not seen by i_eff until the next inst_done. This models the 6502 one-instruction CLI/SEI/PLP delay.
  - irq_entry does not bypass this delay: I rises next cycle, and i_eff follows at the next inst_done.
- irq_mask_eff = i_eff.

Test Plan:
- Reset: assert rst_n=0 between edges with brk_push=0 -> p_out=8'h24 and irq_mask_eff=1 immediately; with brk_push=1 -> p_out=8'h34.
- ALU update: alu_carry=1, alu_zero=1, alu_sign=0, alu_overflow=1, upd_nvzc=4'b1011 -> next cycle C=1, Z=1, N=0, V unchanged (0); p_out=8'h27. Same cycle with flag_op=CLC -> C still 1.
- PLP / BIT: p_load with p_din=8'hFF -> flags_nvdizc=6'b111111, p_out=8'hEF with brk_push=0. Then bit_load with p_din=8'h40, upd_nvzc=4'b0010, alu_zero=0 -> N=0, V=1, Z=0.
- Branches: flags N=0, V=1, C=1, Z=0; sweep br_cond 0..7 -> br_taken = 1,0,0,1,0,1,1,0.
- CLI delay: I=1, i_eff=1; flag_op=CLI with inst_done=1 -> I=0, irq_mask_eff stays 1; next inst_done -> irq_mask_eff=0. Repeat SEI+inst_done from I=0 -> irq_mask_eff stays 0 for one instruction.
- Interrupt entry: irq_entry=1 with p_load, p_din=8'h00 -> I=1, others 0, D unchanged; assert rst_n=0 mid-sequence -> all flags return to reset values asynchronously.
